// File: rtl/uart_rx_if.sv
// Receiver-side UART signal bundle.
// master drives the line and the clear; slave is the receiver.
interface uart_rx_if #(
  parameter int UARTSIZE = 8
);
  logic                RX;
  logic                clearInterrupt;
  logic [UARTSIZE-1:0] ReceivedData;
  logic                RXInterruptFlag;
  logic                PARITYERRORFlag;
  logic                FRAMEERRORFlag;
  logic                OverrunFlag;

  modport master (
    output RX,
    output clearInterrupt,
    input  ReceivedData,
    input  RXInterruptFlag,
    input  PARITYERRORFlag,
    input  FRAMEERRORFlag,
    input  OverrunFlag
  );

  modport slave (
    input  RX,
    input  clearInterrupt,
    output ReceivedData,
    output RXInterruptFlag,
    output PARITYERRORFlag,
    output FRAMEERRORFlag,
    output OverrunFlag
  );
endinterface

// File: rtl/uart_rx_oversampled.sv
// 16x oversampled UART receiver with even-style XOR parity,
// frame/overrun detection and majority-of-three bit decisions.
module uart_rx_oversampled #(
  parameter int UARTSIZE      = 8,
  parameter int CLKS_PER_TICK = 27
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                RX,
  input  logic                clearInterrupt,
  output logic [UARTSIZE-1:0] ReceivedData,
  output logic                RXInterruptFlag,
  output logic                PARITYERRORFlag,
  output logic                FRAMEERRORFlag,
  output logic                OverrunFlag
);

  localparam int DW =
    (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
  localparam int BW =
    (UARTSIZE > 1) ? $clog2(UARTSIZE) : 1;
  localparam logic [DW-1:0] DIV_LAST =
    DW'(CLKS_PER_TICK - 1);
  localparam logic [BW-1:0] BIT_LAST =
    BW'(UARTSIZE - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t              state;
  logic                rxMeta;
  logic                rxS;
  logic                rxD;
  logic [DW-1:0]       divCnt;
  logic [3:0]          sampleCnt;
  logic [BW-1:0]       bitCnt;
  logic                s7;
  logic                s8;
  logic                parityBit;
  logic [UARTSIZE-1:0] shiftReg;

  logic tick;
  logic decide;
  logic boundary;
  logic maj;

  assign tick     = (state != IDLE) && (divCnt == DIV_LAST);
  assign decide   = tick && (sampleCnt == 4'd9);
  assign boundary = tick && (sampleCnt == 4'd15);
  // third vote is the live count-9 sample
  assign maj = (s7 & s8) | (s7 & rxS) | (s8 & rxS);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      rxMeta          <= 1'b1;
      rxS             <= 1'b1;
      rxD             <= 1'b1;
      divCnt          <= '0;
      sampleCnt       <= '0;
      bitCnt          <= '0;
      s7              <= 1'b0;
      s8              <= 1'b0;
      parityBit       <= 1'b0;
      shiftReg        <= '0;
      ReceivedData    <= '0;
      RXInterruptFlag <= 1'b0;
      PARITYERRORFlag <= 1'b0;
      FRAMEERRORFlag  <= 1'b0;
      OverrunFlag     <= 1'b0;
    end else begin
      rxMeta <= RX;
      rxS    <= rxMeta;
      rxD    <= rxS;

      if (clearInterrupt) begin
        RXInterruptFlag <= 1'b0;
        OverrunFlag     <= 1'b0;
      end

      if (state == IDLE || tick)
        divCnt <= '0;
      else
        divCnt <= divCnt + DW'(1);

      if (tick) begin
        sampleCnt <= sampleCnt + 4'd1;
        if (sampleCnt == 4'd7) s7 <= rxS;
        if (sampleCnt == 4'd8) s8 <= rxS;
      end

      unique case (state)
        IDLE: begin
          if (rxD && !rxS) begin
            state     <= START;
            divCnt    <= '0;
            sampleCnt <= '0;
            bitCnt    <= '0;
          end
        end
        START: begin
          if (decide && maj)
            state <= IDLE;
          else if (boundary)
            state <= DATA;
        end
        DATA: begin
          if (decide)
            shiftReg <= {maj, shiftReg[UARTSIZE-1:1]};
          if (boundary) begin
            if (bitCnt == BIT_LAST)
              state <= PARITY;
            else
              bitCnt <= bitCnt + BW'(1);
          end
        end
        PARITY: begin
          if (decide)
            parityBit <= maj;
          else if (boundary)
            state <= STOP;
        end
        STOP: begin
          // leave mid-stop-bit so the next start edge is seen
          if (decide) begin
            state           <= IDLE;
            ReceivedData    <= shiftReg;
            PARITYERRORFlag <= (^shiftReg) != parityBit;
            FRAMEERRORFlag  <= !maj;
            RXInterruptFlag <= 1'b1;
            if (RXInterruptFlag && !clearInterrupt)
              OverrunFlag <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Directed bench for uart_rx_oversampled at 4 clk per tick.
// One bit lasts 64 clk; frames are driven cycle-exact.
module tb_uart_rx_oversampled;

  logic clk;
  logic reset;
  int   cyc;
  int   riseCyc;
  logic flagPrev;
  int   checks;
  int   errors;
  int   startCyc;
  int   lat;

  uart_rx_if #(.UARTSIZE(8)) bus ();

  uart_rx_oversampled #(
    .UARTSIZE(8),
    .CLKS_PER_TICK(4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .RX             (bus.RX),
    .clearInterrupt (bus.clearInterrupt),
    .ReceivedData   (bus.ReceivedData),
    .RXInterruptFlag(bus.RXInterruptFlag),
    .PARITYERRORFlag(bus.PARITYERRORFlag),
    .FRAMEERRORFlag (bus.FRAMEERRORFlag),
    .OverrunFlag    (bus.OverrunFlag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    riseCyc  = 0;
    flagPrev = 1'b0;
  end
  always @(negedge clk) begin
    if (bus.RXInterruptFlag && !flagPrev)
      riseCyc = cyc;
    flagPrev = bus.RXInterruptFlag;
  end

  task automatic waitClk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic sendFrame(input logic [7:0] data,
                           input logic par,
                           input logic stp);
    bus.RX = 1'b0;
    waitClk(64);
    for (int i = 0; i < 8; i++) begin
      bus.RX = data[i];
      waitClk(64);
    end
    bus.RX = par;
    waitClk(64);
    bus.RX = stp;
    waitClk(64);
    bus.RX = 1'b1;
  endtask

  task automatic pulseClear();
    bus.clearInterrupt = 1'b1;
    waitClk(1);
    bus.clearInterrupt = 1'b0;
    waitClk(1);
  endtask

  initial begin
    checks             = 0;
    errors             = 0;
    reset              = 1'b0;
    bus.RX             = 1'b1;
    bus.clearInterrupt = 1'b0;
    waitClk(3);
    check("rst_data", bus.ReceivedData, 8'h00);
    check("rst_int", bus.RXInterruptFlag, 0);
    check("rst_pe", bus.PARITYERRORFlag, 0);
    check("rst_fe", bus.FRAMEERRORFlag, 0);
    check("rst_ovr", bus.OverrunFlag, 0);
    reset = 1'b1;
    waitClk(10);

    startCyc = cyc;
    sendFrame(8'hA5, 1'b0, 1'b1);
    waitClk(4);
    check("a5_data", bus.ReceivedData, 8'hA5);
    check("a5_int", bus.RXInterruptFlag, 1);
    check("a5_pe", bus.PARITYERRORFlag, 0);
    check("a5_fe", bus.FRAMEERRORFlag, 0);
    check("a5_ovr", bus.OverrunFlag, 0);
    lat = riseCyc - (startCyc + 2);
    check("a5_latency", (lat >= 679 && lat <= 681), 1);

    pulseClear();
    check("clr_int", bus.RXInterruptFlag, 0);

    sendFrame(8'h01, 1'b0, 1'b1);
    waitClk(4);
    check("p01_data", bus.ReceivedData, 8'h01);
    check("p01_pe", bus.PARITYERRORFlag, 1);
    check("p01_int", bus.RXInterruptFlag, 1);
    check("p01_ovr", bus.OverrunFlag, 0);
    pulseClear();
    check("pe_hold", bus.PARITYERRORFlag, 1);
    check("pe_clr_int", bus.RXInterruptFlag, 0);

    bus.RX = 1'b0;
    waitClk(20);
    bus.RX = 1'b1;
    waitClk(100);
    check("glitch_int", bus.RXInterruptFlag, 0);
    check("glitch_state", dut.state, 0);
    check("glitch_data", bus.ReceivedData, 8'h01);

    bus.RX = 1'b0;
    sendFrame(8'h5A, 1'b0, 1'b0);
    bus.RX = 1'b0;
    waitClk(1);
    check("fe_flag", bus.FRAMEERRORFlag, 1);
    check("fe_int", bus.RXInterruptFlag, 1);
    check("fe_data", bus.ReceivedData, 8'h5A);
    check("fe_pe", bus.PARITYERRORFlag, 0);
    pulseClear();
    waitClk(200);
    check("lowhold_state", dut.state, 0);
    check("lowhold_int", bus.RXInterruptFlag, 0);
    bus.RX = 1'b1;
    waitClk(20);

    sendFrame(8'h3C, 1'b0, 1'b1);
    sendFrame(8'hC3, 1'b0, 1'b1);
    waitClk(2);
    check("ovr_data", bus.ReceivedData, 8'hC3);
    check("ovr_flag", bus.OverrunFlag, 1);
    check("ovr_int", bus.RXInterruptFlag, 1);
    check("ovr_fe", bus.FRAMEERRORFlag, 0);
    pulseClear();
    check("ovr_clr_int", bus.RXInterruptFlag, 0);
    check("ovr_clr_flag", bus.OverrunFlag, 0);

    sendFrame(8'h96, 1'b0, 1'b1);
    waitClk(2);
    check("pre_int", bus.RXInterruptFlag, 1);
    fork
      sendFrame(8'h0F, 1'b0, 1'b1);
      begin
        waitClk(682);
        bus.clearInterrupt = 1'b1;
        waitClk(1);
        bus.clearInterrupt = 1'b0;
      end
    join
    waitClk(2);
    check("coin_int", bus.RXInterruptFlag, 1);
    check("coin_ovr", bus.OverrunFlag, 0);
    check("coin_data", bus.ReceivedData, 8'h0F);

    bus.RX = 1'b0;
    waitClk(64);
    bus.RX = 1'b1;
    waitClk(64);
    bus.RX = 1'b0;
    waitClk(30);
    reset = 1'b0;
    #1;
    check("mid_rst_data", bus.ReceivedData, 8'h00);
    check("mid_rst_int", bus.RXInterruptFlag, 0);
    check("mid_rst_pe", bus.PARITYERRORFlag, 0);
    check("mid_rst_fe", bus.FRAMEERRORFlag, 0);
    check("mid_rst_ovr", bus.OverrunFlag, 0);
    check("mid_rst_state", dut.state, 0);
    waitClk(2);
    bus.RX = 1'b1;
    waitClk(2);
    reset = 1'b1;
    waitClk(100);
    check("post_rst_state", dut.state, 0);
    check("post_rst_int", bus.RXInterruptFlag, 0);

    sendFrame(8'h5C, 1'b0, 1'b1);
    waitClk(2);
    check("post_data", bus.ReceivedData, 8'h5C);
    check("post_int", bus.RXInterruptFlag, 1);
    check("post_pe", bus.PARITYERRORFlag, 0);
    check("post_fe", bus.FRAMEERRORFlag, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_oversampled.md
UART_RX_OVERSAMPLED -- requirements
Module: uart_rx_oversampled

Interface
REQ-001 The module SHALL have parameter UARTSIZE, default 8, giving the data bits per frame.
REQ-002 The module SHALL have parameter CLKS_PER_TICK, default 27, giving clk cycles per oversample tick (16 ticks per bit).
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-004 The module SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The module SHALL have port RX, input, 1 bit: serial line, idle high, asynchronous to clk.
REQ-006 The module SHALL have port clearInterrupt, input, 1 bit: synchronous clear of RXInterruptFlag and OverrunFlag.
REQ-007 The module SHALL have port ReceivedData, output, UARTSIZE bits: last received data word.
REQ-008 The module SHALL have port RXInterruptFlag, output, 1 bit: a frame has completed and has not been cleared.
REQ-009 The module SHALL have port PARITYERRORFlag, output, 1 bit: parity status of the last frame.
REQ-010 The module SHALL have port FRAMEERRORFlag, output, 1 bit: stop-bit status of the last frame.
REQ-011 The module SHALL have port OverrunFlag, output, 1 bit: a frame completed while RXInterruptFlag was still set.

Function
REQ-012 Frame format SHALL be: start bit 0, then UARTSIZE data bits LSB-first, then parity bit equal to XOR of the data bits, then stop bit 1.
REQ-013 RX SHALL pass through a two-flop synchronizer; all internal logic SHALL use only the synchronized value (rx_s).
REQ-014 The tick divider SHALL count 0..CLKS_PER_TICK-1 and pulse tick for one clk at the terminal count; it runs freely outside IDLE.
REQ-015 The divider and the 4-bit sample counter SHALL be cleared on every entry to START.
REQ-016 Each bit SHALL span sample counts 0..15, with one count per tick; the count wraps 15->0 on the bit boundary.
REQ-017 Bit value SHALL be the majority of rx_s at sample counts 7, 8 and 9; the decision takes effect on the tick that completes count 9.
REQ-018 The FSM SHALL have states IDLE, START, DATA, PARITY and STOP.
REQ-019 IDLE->START SHALL occur on an rx_s 1->0 transition.
REQ-020 START SHALL go to DATA if the majority is 0, else return to IDLE (false start).
REQ-021 In DATA, each decided bit SHALL be shifted into a UARTSIZE-bit shift register from the MSB side, shifting right.
REQ-022 DATA SHALL go to PARITY after the UARTSIZE-th bit boundary, counted by a bit counter.
REQ-023 PARITY SHALL latch the decided parity bit, then go to STOP at the bit boundary.
REQ-024 STOP SHALL return to IDLE on the decision cycle (mid-stop-bit), so a start edge immediately after the stop bit is detected.
REQ-025 On the STOP decision cycle, ReceivedData SHALL load the shift register.
REQ-026 On the STOP decision cycle, PARITYERRORFlag SHALL be set to (XOR of data) != parity bit.
REQ-027 On the STOP decision cycle, FRAMEERRORFlag SHALL be set to NOT(stop bit).
REQ-028 On the STOP decision cycle, RXInterruptFlag SHALL be set to 1.
REQ-029 On the STOP decision cycle, OverrunFlag SHALL be set to 1 if RXInterruptFlag was 1 and clearInterrupt is 0 in that cycle.
REQ-030 On overrun, data and error flags SHALL be overwritten with the new frame.
REQ-031 If clearInterrupt coincides with a STOP decision, the set SHALL win: RXInterruptFlag=1 and OverrunFlag unchanged.
REQ-032 PARITYERRORFlag and FRAMEERRORFlag SHALL hold until the next frame completes; clearInterrupt SHALL NOT affect them.
REQ-033 A frame with a frame error SHALL still be delivered; IDLE then waits for a fresh 1->0 edge, so an RX held low SHALL NOT retrigger.
REQ-034 Latency from the synchronized falling edge to RXInterruptFlag SHALL be ((UARTSIZE+2)*16+10)*CLKS_PER_TICK clk cycles, +/-1 clk.

Reset
REQ-035 Asserting reset (reset=0) SHALL immediately force state IDLE, clear all counters, set the synchronizer flops to 1, and clear the shift register.
REQ-036 Asserting reset (reset=0) SHALL immediately drive ReceivedData=0 and all four flags to 0.
REQ-037 Reset during a frame SHALL abandon that frame; after release, reception SHALL restart only on a new falling edge.

Verification (CLKS_PER_TICK=4, so 1 bit = 64 clk)
REQ-038 The bench SHALL drive frame data 0xA5, parity 0, stop 1 and check ReceivedData=0xA5, RXInterruptFlag=1, PARITYERRORFlag=0, FRAMEERRORFlag=0, and flag rise at 10*64+40 clk +/-1 after the sync edge.
REQ-039 The bench SHALL drive data 0x01 with parity 0 and check ReceivedData=0x01 and PARITYERRORFlag=1.
REQ-040 The bench SHALL drive a 20-clk low pulse on idle RX and check no flag change and FSM back in IDLE; it SHALL also drive a frame with stop bit 0 and check FRAMEERRORFlag=1 with RXInterruptFlag=1.
REQ-041 The bench SHALL send two back-to-back frames (0x3C then 0xC3) without clearInterrupt and check ReceivedData=0xC3 and OverrunFlag=1; a following clearInterrupt pulse SHALL clear both flags.
REQ-042 The bench SHALL assert clearInterrupt on the exact STOP decision cycle and check RXInterruptFlag=1 afterwards.
REQ-043 The bench SHALL assert reset mid-DATA and check all outputs 0 immediately; a correct frame after release SHALL be received normally.
